chunked_adder_n: RTL and testbench



---
 rtl/adder_pkg.sv | 27 ++
 rtl/adder_chunk.sv | 33 +++
 rtl/chunked_adder_n.sv | 162 ++++++++++++++++
 tb/tb_chunked_adder_n.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared types and sizing helpers for the chunked adder.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

  // Controller states of the chunk-serial adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-bit slices in a WIDTH-bit operand.
  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Width of a field able to hold 0..nchunk inclusive.
  function automatic int calc_lw(input int nchunk);
    return $clog2(nchunk + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_chunk.sv
`default_nettype none
// ============================================================================
// Module      : adder_chunk
// Description : Combinational CHUNK-bit adder slice. Also reports the carry
//               into the MSB so the caller can derive signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0]   full_sum;
  logic [CHUNK-1:0] low_sum;

  // Full-width sum gives result and carry-out; a sum of the bits below the
  // MSB exposes the carry into the MSB.
  always_comb begin
    full_sum = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    low_sum  = {1'b0, a[CHUNK-2:0]} + {1'b0, b[CHUNK-2:0]} + {{(CHUNK-1){1'b0}}, ci};
    s        = full_sum[CHUNK-1:0];
    co       = full_sum[CHUNK];
    c_msb    = low_sum[CHUNK-1];
  end

endmodule
`default_nettype wire

// File: rtl/chunked_adder_n.sv
`default_nettype none
// ============================================================================
// Module      : chunked_adder_n
// Description : Multi-cycle add/subtract unit. Processes one CHUNK-bit slice
//               per clock, LSB first, with a carry register between slices.
//               Active width is selectable per transaction in whole chunks.
//               valid/ready handshakes on both input and output sides.
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_adder_n
  import adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK),
  localparam int LW = calc_lw(NCHUNK)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [LW-1:0]    len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [LW-1:0]    idx_q, idx_d;
  logic [LW-1:0]    len_q, len_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co;
  logic             chunk_c_msb;
  logic             last_chunk;

  // Select the operand slice addressed by the current chunk index.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == LW'(i)) begin
        chunk_a = a_q[i*CHUNK +: CHUNK];
        chunk_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // Single slice adder, reused on every CALC cycle.
  adder_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (chunk_a),
    .b     (chunk_b),
    .ci    (carry_q),
    .s     (chunk_s),
    .co    (chunk_co),
    .c_msb (chunk_c_msb)
  );

  assign last_chunk = (idx_q == (len_q - LW'(1)));

  // Next-state logic: capture on accept, accumulate slices, hold until drained.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          // Subtraction is a + ~b + cin; the caller supplies cin=1 for a
          // true two's-complement difference.
          b_d     = sub ? ~b : b;
          carry_d = cin;
          // A zero length selects the full operand width.
          len_d   = (len == '0) ? LW'(NCHUNK) : len;
          sum_d   = '0;
          idx_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < NCHUNK; i++) begin
          if (idx_q == LW'(i)) begin
            sum_d[i*CHUNK +: CHUNK] = chunk_s;
          end
        end
        carry_d = chunk_co;
        idx_d   = idx_q + LW'(1);
        if (last_chunk) begin
          cout_d  = chunk_co;
          ovf_d   = chunk_c_msb ^ chunk_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      len_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_chunked_adder_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunked_adder_n
// Description : Directed self-checking bench for chunked_adder_n.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chunked_adder_n;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;
  logic [2:0]  len;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;

  int checks;
  int errors;

  chunked_adder_n #(
    .WIDTH (64),
    .CHUNK (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .len       (len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for in_ready, then present operands for one edge.
  task automatic issue(input logic [63:0] ta, input logic [63:0] tb_v,
                       input logic tcin, input logic tsub, input logic [2:0] tlen,
                       input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    a        = ta;
    b        = tb_v;
    cin      = tcin;
    sub      = tsub;
    len      = tlen;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count cycles from the accepting edge until out_valid (bounded).
  task automatic wait_result(input int elat, input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(elat));
  endtask

  // Complete the output handshake and confirm return to IDLE.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_rdy_after"}, {63'd0, in_ready}, 64'd1);
    check({tag, "_ov_after"}, {63'd0, out_valid}, 64'd0);
  endtask

  // Full transaction with result checks.
  task automatic run_txn(input logic [63:0] ta, input logic [63:0] tb_v,
                         input logic tcin, input logic tsub, input logic [2:0] tlen,
                         input logic [63:0] es, input logic ec, input logic eo,
                         input int elat, input string tag);
    issue(ta, tb_v, tcin, tsub, tlen, tag);
    wait_result(elat, tag);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
    check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    len       = 3'd0;

    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Full-width carry ripple through all four chunks.
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 3'd4,
            64'd0, 1'b1, 1'b0, 4, "t1");
    // Single-chunk signed overflow.
    run_txn(64'h0000_0000_0000_7FFF, 64'd1, 1'b0, 1'b0, 3'd1,
            64'h0000_0000_0000_8000, 1'b0, 1'b1, 1, "t2");
    // Subtraction with borrow: 5 - 7.
    run_txn(64'd5, 64'd7, 1'b1, 1'b1, 3'd4,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4, "t3");
    // Two chunks: upper operand bits ignored, upper sum bits zero.
    run_txn(64'hAAAA_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 3'd2,
            64'd0, 1'b1, 1'b0, 2, "t4");
    // len=0 means full width.
    run_txn(64'hAAAA_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 3'd0,
            64'hAAAA_0001_0000_0000, 1'b0, 1'b0, 4, "t5");
    // Subtraction without borrow: 10 - 3 over two chunks.
    run_txn(64'd10, 64'd3, 1'b1, 1'b1, 3'd2,
            64'd7, 1'b1, 1'b0, 2, "t6");
    // Three chunks, carry-in feeds chunk 0.
    run_txn(64'h0000_1234_FFFF_FFFF, 64'h0000_0001_0000_0000, 1'b1, 1'b0, 3'd3,
            64'h0000_1236_0000_0000, 1'b0, 1'b0, 3, "t7");

    // Backpressure: result held while inputs toggle.
    issue(64'd1, 64'd2, 1'b0, 1'b0, 3'd1, "hold");
    wait_result(1, "hold");
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a        = ~a;
      b        = b + 64'd17;
      @(posedge clk);
      #1;
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("hold_sum", sum, 64'd3);
      check("hold_cout", {63'd0, cout}, 64'd0);
      check("hold_ovf", {63'd0, ovf}, 64'd0);
    end
    in_valid = 1'b0;
    drain("hold");

    // Reset during the second CALC cycle.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3'd4, "abort");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_sum", sum, 64'd0);
    check("abort_cout", {63'd0, cout}, 64'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_txn(64'd3, 64'd4, 1'b0, 1'b0, 3'd4,
            64'd7, 1'b0, 1'b0, 4, "post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
